tex_spi_fetch: RTL and testbench

Parametrised texture-slice fetch engine for an external SPI flash. It generalises the fixed 64×1-bit per-line texture read into a triggered, configurable-length READ. The fetched data lands in a double buffer. A combinational texel read port serves the row renderer while the next slice streams in. It sits between `wall_tracer` (slice address) and the pixel path (texel colour), and is triggered near line end.

---
 rtl/tex_spi_fetch.sv | 242 ++++++++++++++++++++++++
 tb/tb_tex_spi_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tex_spi_fetch.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tex_spi_fetch
// Fetches one texture slice from an external SPI flash with a READ command
// and exposes it to the row renderer through a combinational texel port.
// Data streams into a back buffer. A shadow copy holds the last complete
// slice, so a swap during a fetch never exposes a partial slice.
//
// Build option: `TEX_SPI_FAST_READ_EN selects FAST READ (0Bh) with 8 dummy
// cycles. When it is undefined, plain READ (03h) is used with no dummy phase.
//
// Ports:
//   clk          system clock (single domain)
//   reset_n      asynchronous active-low reset
//   i_start      pulse, begins a fetch when idle
//   i_slice      slice index, latched on an accepted start
//   i_swap       pulse, publish last completed slice to the front buffer
//   i_texv       texel index into the front buffer
//   o_texel      front[i_texv*BPP +: BPP], 0 while no valid data
//   o_busy       fetch in progress
//   o_done       one-cycle pulse when a slice completes
//   o_valid      front buffer holds completed data
//   o_tex_csb    SPI chip select (active low)
//   o_tex_sclk   SPI clock (inverted system clock)
//   o_tex_mosi   SPI data to flash
//   i_tex_miso   SPI data from flash
// -----------------------------------------------------------------------------
module tex_spi_fetch #(
  parameter int DATA_BITS   = 64,
  parameter int BPP         = 1,
  parameter int ADDR_BITS   = 24,
  parameter int SLICE_BITS  = 9,
  parameter int SLICE_SHIFT = 3,
  parameter int ADDR_BASE   = 0
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 i_start,
  input  logic [SLICE_BITS-1:0]                i_slice,
  input  logic                                 i_swap,
  input  logic [$clog2(DATA_BITS/BPP)-1:0]     i_texv,
  output logic [BPP-1:0]                       o_texel,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_valid,
  output logic                                 o_tex_csb,
  output logic                                 o_tex_sclk,
  output logic                                 o_tex_mosi,
  input  logic                                 i_tex_miso
);

  localparam int CMD_LEN = 8;
`ifdef TEX_SPI_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE  = 8'h0B;
  localparam int         DUMMY_LEN = 8;
`else
  localparam logic [7:0] CMD_BYTE  = 8'h03;
  localparam int         DUMMY_LEN = 0;
`endif
  localparam int MAX_A   = (CMD_LEN > ADDR_BITS) ? CMD_LEN : ADDR_BITS;
  localparam int MAX_B   = (DUMMY_LEN > DATA_BITS) ? DUMMY_LEN : DATA_BITS;
  localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_LEN);
  localparam int SR_W    = CMD_LEN + ADDR_BITS;
  localparam int IW      = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
`ifdef TEX_SPI_FAST_READ_EN
    ST_DUMMY = 3'd3,
`endif
    ST_DATA  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SR_W-1:0]        sr_q, sr_d;
  logic [DATA_BITS-1:0]   back_q, back_d;
  logic [DATA_BITS-1:0]   shadow_q, shadow_d;
  logic [DATA_BITS-1:0]   front_q, front_d;
  logic                   have_q, have_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   csb_q, csb_d;
  logic                   mosi_q, mosi_d;
  logic                   done_q, done_d;
  logic                   cap_q, cap_d;
  logic [ADDR_BITS-1:0]   addr_s;
  logic [IW-1:0]          bit_idx_s;

  assign o_tex_sclk = ~clk;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_valid    = valid_q;
  assign o_tex_csb  = csb_q;
  assign o_tex_mosi = mosi_q;
  assign cap_d      = i_tex_miso;

  // Next-state logic: phase sequencing, command/address shifter, buffers, swap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    back_d   = back_q;
    shadow_d = shadow_q;
    front_d  = front_q;
    have_d   = have_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    addr_s   = ADDR_BITS'(ADDR_BASE) + (ADDR_BITS'(i_slice) << SLICE_SHIFT);

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_CMD;
          cnt_d   = {CW{1'b0}};
          sr_d    = {CMD_BYTE, addr_s};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        sr_d = sr_q << 1;
        if (cnt_q == CW'(CMD_LEN - 1)) begin
          state_d = ST_ADDR;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ADDR: begin
        sr_d = sr_q << 1;
        if (cnt_q == CW'(ADDR_BITS - 1)) begin
`ifdef TEX_SPI_FAST_READ_EN
          state_d = ST_DUMMY;
`else
          state_d = ST_DATA;
`endif
          cnt_d = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef TEX_SPI_FAST_READ_EN
      ST_DUMMY: begin
        if (cnt_q == CW'(DUMMY_LEN - 1)) begin
          state_d = ST_DATA;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      ST_DATA: begin
        // First received bit travels down to back[0] after DATA_BITS shifts.
        back_d = {cap_q, back_q[DATA_BITS-1:1]};
        if (cnt_q == CW'(DATA_BITS - 1)) begin
          state_d  = ST_IDLE;
          cnt_d    = {CW{1'b0}};
          done_d   = 1'b1;
          shadow_d = back_d;
          have_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase

    // Using the next-cycle shadow forwards a slice completing on this edge.
    if (i_swap && have_d) begin
      front_d = shadow_d;
      valid_d = 1'b1;
    end else begin
      front_d = front_q;
    end

    busy_d = (state_d != ST_IDLE);
    csb_d  = ~busy_d;
    if ((state_d == ST_CMD) || (state_d == ST_ADDR)) begin
      mosi_d = sr_d[SR_W-1];
    end else begin
      mosi_d = 1'b0;
    end
  end

  // Texel read port: zero latency from index and front buffer.
  always_comb begin
    bit_idx_s = IW'(i_texv) * IW'(BPP);
    if (valid_q) begin
      o_texel = front_q[bit_idx_s +: BPP];
    end else begin
      o_texel = {BPP{1'b0}};
    end
  end

  // MISO capture on rising SCLK (falling clk edge).
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q <= 1'b0;
    end else begin
      cap_q <= cap_d;
    end
  end

  // FSM and all registered state; reset raises CSB asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CW{1'b0}};
      sr_q     <= {SR_W{1'b0}};
      back_q   <= {DATA_BITS{1'b0}};
      shadow_q <= {DATA_BITS{1'b0}};
      front_q  <= {DATA_BITS{1'b0}};
      have_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      csb_q    <= 1'b1;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      back_q   <= back_d;
      shadow_q <= shadow_d;
      front_q  <= front_d;
      have_q   <= have_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      csb_q    <= csb_d;
      mosi_q   <= mosi_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_tex_spi_fetch.sv
`timescale 1ns/1ps
// Directed bench for tex_spi_fetch: a behavioural flash model records the
// command/address bits and returns a repeating byte pattern; two instances
// (BPP=1 and BPP=2) share the same stimulus.
module tb_tex_spi_fetch;

  localparam int ABITS = 24;
`ifdef TEX_SPI_FAST_READ_EN
  localparam logic [7:0] CMD_EXP = 8'h0B;
  localparam int         DUM     = 8;
`else
  localparam logic [7:0] CMD_EXP = 8'h03;
  localparam int         DUM     = 0;
`endif
  localparam int P = 8 + ABITS + DUM;
  localparam int N = P + 64;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_start, i_swap;
  logic [8:0] i_slice;
  logic [5:0] texv1;
  logic [4:0] texv2;
  logic       texel1;
  logic [1:0] texel2;
  logic       busy1, done1, valid1, csb1, sclk1, mosi1;
  logic       busy2, done2, valid2, csb2, sclk2, mosi2;
  logic       miso;

  always #5 clk = ~clk;

  tex_spi_fetch #(.BPP(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_slice(i_slice),
    .i_swap(i_swap), .i_texv(texv1), .o_texel(texel1), .o_busy(busy1),
    .o_done(done1), .o_valid(valid1), .o_tex_csb(csb1), .o_tex_sclk(sclk1),
    .o_tex_mosi(mosi1), .i_tex_miso(miso)
  );

  tex_spi_fetch #(.BPP(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_slice(i_slice),
    .i_swap(i_swap), .i_texv(texv2), .o_texel(texel2), .o_busy(busy2),
    .o_done(done2), .o_valid(valid2), .o_tex_csb(csb2), .o_tex_sclk(sclk2),
    .o_tex_mosi(mosi2), .i_tex_miso(miso)
  );

  // Flash model state
  int          k = 0;
  logic [31:0] rx;
  logic        mosi_bad;
  logic [7:0]  pat;

  // Flash samples MOSI on rising SCLK while selected.
  always @(negedge clk) begin
    if (csb1) begin
      k = 0;
    end else begin
      if (k < 32) rx = {rx[30:0], mosi1};
      else if (mosi1) mosi_bad = 1'b1;
      k = k + 1;
    end
  end

  // Flash drives data bit j shortly after edge E0+P+j.
  always @(posedge clk) begin
    #1;
    if (!csb1 && k >= P) miso = pat[(k - P) % 8];
    else miso = 1'b0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int   done_at, low_cnt, done_cnt;
  logic e0_csb, e0_busy, e0_mosi, snap;

  task automatic run_fetch(input logic [8:0] slice, input logic [7:0] p,
                           input int swap_at, input int start_at);
    pat = p; rx = 32'h0; mosi_bad = 1'b0;
    done_at = -1; low_cnt = 0; done_cnt = 0; snap = 1'bx;
    @(negedge clk); i_start = 1'b1; i_slice = slice;
    @(posedge clk); #1; i_start = 1'b0; i_slice = 9'h1FF;
    e0_csb = csb1; e0_busy = busy1; e0_mosi = mosi1;
    if (!csb1) low_cnt++;
    for (int cyc = 1; cyc <= N + 4; cyc++) begin
      if (cyc == swap_at) i_swap = 1'b1;
      if (cyc == start_at) i_start = 1'b1;
      @(posedge clk); #1;
      i_swap = 1'b0; i_start = 1'b0;
      if (done1) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (!csb1) low_cnt++;
      if (cyc == swap_at) snap = texel1;
    end
  endtask

  task automatic do_swap();
    @(negedge clk); i_swap = 1'b1;
    @(posedge clk); #1; i_swap = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; i_start = 1'b0; i_swap = 1'b0; i_slice = 9'h0;
    texv1 = 6'd0; texv2 = 5'd0; pat = 8'h0; rx = 32'h0; mosi_bad = 1'b0;
    #23;
    check("rst_csb",   32'(csb1),   32'd1);
    check("rst_mosi",  32'(mosi1),  32'd0);
    check("rst_busy",  32'(busy1),  32'd0);
    check("rst_done",  32'(done1),  32'd0);
    check("rst_valid", 32'(valid1), 32'd0);
    check("rst_texel", 32'(texel1), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Swap before any completed fetch must not validate the front buffer
    do_swap();
    check("swap_nodata_valid", 32'(valid1), 32'd0);

    // Fetch 1: slice 1A5, pattern 1111_0000 in arrival order
    run_fetch(9'h1A5, 8'h0F, 0, 0);
    check("e0_csb",  32'(e0_csb),  32'd0);
    check("e0_busy", 32'(e0_busy), 32'd1);
    check("e0_mosi", 32'(e0_mosi), 32'(CMD_EXP[7]));
    check("f1_cmd_addr", rx, {CMD_EXP, 24'h000D28});
    check("f1_mosi_zero", 32'(mosi_bad), 32'd0);
    check("f1_done_at", 32'(done_at), 32'(N));
    check("f1_done_cnt", 32'(done_cnt), 32'd1);
    check("f1_csb_low", 32'(low_cnt), 32'(N));
    check("f1_busy_end", 32'(busy1), 32'd0);
    check("f1_valid_preswap", 32'(valid1), 32'd0);
    do_swap();
    check("f1_valid", 32'(valid1), 32'd1);
    for (int t = 0; t < 8; t++) begin
      texv1 = 6'(t); #1;
      check($sformatf("f1_texel%0d", t), 32'(texel1), (t < 4) ? 32'd1 : 32'd0);
    end
    texv1 = 6'd9;  #1; check("f1_texel9",  32'(texel1), 32'd1);
    texv1 = 6'd62; #1; check("f1_texel62", 32'(texel1), 32'd0);
    texv2 = 5'd0;  #1; check("bpp2_texel0", 32'(texel2), 32'd3);
    texv2 = 5'd2;  #1; check("bpp2_texel2", 32'(texel2), 32'd0);

    // Fetch 2: start at cycle 10 ignored, swap at 50 keeps fetch-1 data
    run_fetch(9'h003, 8'h55, 50, 10);
    check("f2_cmd_addr", rx, {CMD_EXP, 24'h000018});
    check("f2_done_at", 32'(done_at), 32'(N));
    check("f2_csb_low", 32'(low_cnt), 32'(N));
    check("f2_busy_end", 32'(busy1), 32'd0);
    texv1 = 6'd62; #1; check("f2_front62", 32'(texel1), 32'd0);
    texv1 = 6'd4;  #1; check("f2_front4",  32'(texel1), 32'd0);
    texv1 = 6'd1;  #1; check("f2_front1",  32'(texel1), 32'd1);

    // Fetch 3: swap and start on the completion edge
    texv1 = 6'd5;
    run_fetch(9'h000, 8'hAA, N, N);
    check("f3_fwd_snap", 32'(snap), 32'd1);
    check("f3_done_at", 32'(done_at), 32'(N));
    check("f3_start_at_N_ignored", 32'(busy1), 32'd0);
    check("f3_cmd_addr", rx, {CMD_EXP, 24'h000000});
    texv1 = 6'd0; #1; check("f3_front0", 32'(texel1), 32'd0);
    texv1 = 6'd1; #1; check("f3_front1", 32'(texel1), 32'd1);

    // Fetch 4: reset at cycle 40
    @(negedge clk); i_start = 1'b1; i_slice = 9'h005;
    @(posedge clk); #1; i_start = 1'b0;
    repeat (40) @(posedge clk);
    #1; reset_n = 1'b0;
    #1;
    check("rst_mid_csb",   32'(csb1),   32'd1);
    check("rst_mid_valid", 32'(valid1), 32'd0);
    check("rst_mid_busy",  32'(busy1),  32'd0);
    check("rst_mid_texel", 32'(texel1), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    do_swap();
    check("rst_swap_valid", 32'(valid1), 32'd0);

    // Fetch 5: fresh fetch after reset
    run_fetch(9'h1A5, 8'h0F, 0, 0);
    check("f5_done_at", 32'(done_at), 32'(N));
    check("f5_cmd_addr", rx, {CMD_EXP, 24'h000D28});
    do_swap();
    check("f5_valid", 32'(valid1), 32'd1);
    texv1 = 6'd3; #1; check("f5_texel3", 32'(texel1), 32'd1);
    texv1 = 6'd7; #1; check("f5_texel7", 32'(texel1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
